// File: rtl/p_encode_pkg.sv
// Shared constants and state type for the p_encode_dat packing stage and its skid buffer.
package p_encode_pkg;

  localparam int DEF_SLICES = 4;
  localparam int DEF_PERIN  = 16;
  localparam int DEF_SELOU  = 8;
  localparam int DEF_RPTW   = 8;

  localparam int DAT_W = DEF_SLICES * DEF_PERIN;
  localparam int KP_W  = DEF_SELOU + DAT_W;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } enc_state_t;

  function automatic int kp_width(input int slices, input int perin, input int selou);
    return selou + slices * perin;
  endfunction

endpackage

// File: rtl/p_encode_dat_if.sv
// Data, control and packed-output handshake bundle of the p_encode_dat stage.
interface p_encode_dat_if
  import p_encode_pkg::*;
#(
  parameter int SLICES = DEF_SLICES,
  parameter int PERIN  = DEF_PERIN,
  parameter int SELOU  = DEF_SELOU,
  parameter int RPTW   = DEF_RPTW
);

  localparam int DW = SLICES * PERIN;
  localparam int KW = SELOU + DW;

  logic [DW-1:0]    d_dat;
  logic             d_valid;
  logic             d_ready;
  logic [SELOU-1:0] c_ctrl;
  logic [RPTW-1:0]  c_rpt;
  logic             c_valid;
  logic             c_ready;
  logic [KW-1:0]    t_kp_dat;
  logic             t_valid;
  logic             t_ready;

  modport slave (
    input  d_dat, d_valid, c_ctrl, c_rpt, c_valid, t_ready,
    output d_ready, c_ready, t_kp_dat, t_valid
  );

  modport master (
    output d_dat, d_valid, c_ctrl, c_rpt, c_valid, t_ready,
    input  d_ready, c_ready, t_kp_dat, t_valid
  );

endinterface

// File: rtl/p_skid2.sv
// Two-entry valid/ready skid buffer; o_dat always presents the oldest entry.
module p_skid2
  import p_encode_pkg::*;
#(
  parameter int W = KP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_dat,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_dat,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic         w_push;
  logic         w_pop;

  // Ready depends only on occupancy so it never combinationally follows i_ready.
  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_dat   = r_ent0;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= i_dat;
          else               r_ent1 <= i_dat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        // Push with pop only happens at count 1 (count 2 blocks the push).
        2'b11: r_ent0 <= i_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/p_encode_dat.sv
// Joins a data-beat stream with a repeat-counted control stream into {k_ctrl, data} words.
// Optional macro P_ENCODE_DAT_STATS_EN adds beat_cnt / ctrl_cnt statistics outputs.
module p_encode_dat
  import p_encode_pkg::*;
#(
  parameter int SLICES = DEF_SLICES,
  parameter int PERIN  = DEF_PERIN,
  parameter int SELOU  = DEF_SELOU,
  parameter int RPTW   = DEF_RPTW
) (
  input  logic                 clk,
  input  logic                 reset,
  p_encode_dat_if.slave        bus
`ifdef P_ENCODE_DAT_STATS_EN
  ,
  output logic [31:0]          beat_cnt,
  output logic [31:0]          ctrl_cnt
`endif
);

  localparam int DW = SLICES * PERIN;
  localparam int KW = SELOU + DW;

  enc_state_t       r_state;
  logic [SELOU-1:0] r_ctrl;
  logic [RPTW-1:0]  r_rem;
  logic             w_skid_ready;
  logic             w_d_fire;
  logic             w_c_fire;
  logic             w_last;

  assign bus.d_ready = !reset && (r_state == LOADED) && w_skid_ready;
  assign w_d_fire    = bus.d_valid && bus.d_ready;
  assign w_last      = (r_rem == '0);
  // A new control may load on the cycle the last beat of the current one fires.
  assign bus.c_ready = !reset && ((r_state == EMPTY) || (w_last && w_d_fire));
  assign w_c_fire    = bus.c_valid && bus.c_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ctrl  <= '0;
      r_rem   <= '0;
    end else if (w_c_fire) begin
      r_state <= LOADED;
      r_ctrl  <= bus.c_ctrl;
      r_rem   <= bus.c_rpt;
    end else if (w_d_fire) begin
      if (w_last) r_state <= EMPTY;
      else        r_rem   <= r_rem - RPTW'(1);
    end
  end

  // The fired beat is tagged with the control already held, never the incoming one.
  p_skid2 #(
    .W (KW)
  ) u_skid (
    .clk     (clk),
    .rst     (reset),
    .i_dat   ({r_ctrl, bus.d_dat}),
    .i_valid (w_d_fire),
    .o_ready (w_skid_ready),
    .o_dat   (bus.t_kp_dat),
    .o_valid (bus.t_valid),
    .i_ready (bus.t_ready)
  );

`ifdef P_ENCODE_DAT_STATS_EN
  logic w_pop;
  assign w_pop = bus.t_valid && bus.t_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      ctrl_cnt <= '0;
    end else begin
      if (w_pop)    beat_cnt <= beat_cnt + 32'd1;
      if (w_c_fire) ctrl_cnt <= ctrl_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_p_encode_dat.sv
// Directed, table-driven bench for p_encode_dat with hand-written multi-cycle sequences.
module tb_p_encode_dat;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  p_encode_dat_if #(.SLICES(4), .PERIN(16), .SELOU(8), .RPTW(8)) bus ();

`ifdef P_ENCODE_DAT_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] ctrl_cnt;
`endif

  p_encode_dat #(.SLICES(4), .PERIN(16), .SELOU(8), .RPTW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef P_ENCODE_DAT_STATS_EN
    ,
    .beat_cnt (beat_cnt),
    .ctrl_cnt (ctrl_cnt)
`endif
  );

  typedef struct {
    logic        cv;
    logic [7:0]  cc;
    logic [7:0]  cr;
    logic        dv;
    logic [63:0] dd;
    logic        tr;
    logic        ecr;
    logic        edr;
    logic        etv;
    logic [71:0] ekp;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [7:0] cc, input logic [7:0] cr,
                       input logic dv, input logic [63:0] dd, input logic tr);
    bus.c_valid = cv;
    bus.c_ctrl  = cc;
    bus.c_rpt   = cr;
    bus.d_valid = dv;
    bus.d_dat   = dd;
    bus.t_ready = tr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 8'h0, 8'h0, 0, 64'h0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int first_cr;
    int words;
    int bad;

    //              cv cc     cr    dv dd                      tr  ecr edr etv ekp
    tbl[0]  = '{1, 8'hA5, 8'd0, 0, 64'h0,                  1,  1,  0,  0,  72'h0};
    tbl[1]  = '{0, 8'h00, 8'd0, 1, 64'h0123_4567_89AB_CDEF, 1, 1,  1,  0,  72'h0};
    tbl[2]  = '{0, 8'h00, 8'd0, 0, 64'h0,                  1,  1,  0,  1,  72'hA5_0123456789ABCDEF};
    tbl[3]  = '{1, 8'h3C, 8'd3, 0, 64'h0,                  1,  1,  0,  0,  72'h0};
    tbl[4]  = '{0, 8'h00, 8'd0, 1, 64'h1,                  1,  0,  1,  0,  72'h0};
    tbl[5]  = '{0, 8'h00, 8'd0, 1, 64'h2,                  1,  0,  1,  1,  {8'h3C, 64'h1}};
    tbl[6]  = '{0, 8'h00, 8'd0, 1, 64'h3,                  1,  0,  1,  1,  {8'h3C, 64'h2}};
    tbl[7]  = '{0, 8'h00, 8'd0, 1, 64'h4,                  1,  1,  1,  1,  {8'h3C, 64'h3}};
    tbl[8]  = '{1, 8'h11, 8'd0, 0, 64'h0,                  1,  1,  0,  1,  {8'h3C, 64'h4}};
    tbl[9]  = '{1, 8'h22, 8'd1, 1, 64'h5,                  1,  1,  1,  0,  72'h0};
    tbl[10] = '{0, 8'h00, 8'd0, 1, 64'h6,                  1,  0,  1,  1,  {8'h11, 64'h5}};
    tbl[11] = '{0, 8'h00, 8'd0, 1, 64'h7,                  1,  1,  1,  1,  {8'h22, 64'h6}};
    tbl[12] = '{1, 8'h77, 8'd7, 0, 64'h0,                  1,  1,  0,  1,  {8'h22, 64'h7}};
    tbl[13] = '{0, 8'h00, 8'd0, 1, 64'h8,                  0,  0,  1,  0,  72'h0};
    tbl[14] = '{0, 8'h00, 8'd0, 1, 64'h9,                  0,  0,  1,  1,  {8'h77, 64'h8}};
    tbl[15] = '{0, 8'h00, 8'd0, 1, 64'hA,                  0,  0,  0,  1,  {8'h77, 64'h8}};
    tbl[16] = '{0, 8'h00, 8'd0, 1, 64'hA,                  0,  0,  0,  1,  {8'h77, 64'h8}};
    tbl[17] = '{0, 8'h00, 8'd0, 1, 64'hA,                  0,  0,  0,  1,  {8'h77, 64'h8}};
    tbl[18] = '{0, 8'h00, 8'd0, 1, 64'hA,                  1,  0,  0,  1,  {8'h77, 64'h8}};
    tbl[19] = '{0, 8'h00, 8'd0, 1, 64'hA,                  1,  0,  1,  1,  {8'h77, 64'h9}};
    tbl[20] = '{0, 8'h00, 8'd0, 0, 64'h0,                  1,  0,  1,  1,  {8'h77, 64'hA}};
    tbl[21] = '{0, 8'h00, 8'd0, 0, 64'h0,                  1,  0,  1,  0,  72'h0};

    // Outputs while reset is held.
    reset = 1'b1;
    drive(0, 8'h0, 8'h0, 1, 64'hFFFF, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst c_ready", 72'(bus.c_ready), 72'h0);
    chk("rst d_ready", 72'(bus.d_ready), 72'h0);
    chk("rst t_valid", 72'(bus.t_valid), 72'h0);
    chk("rst t_kp_dat", bus.t_kp_dat, 72'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cv, tbl[i].cc, tbl[i].cr, tbl[i].dv, tbl[i].dd, tbl[i].tr);
      @(negedge clk);
      chk($sformatf("v%0d c_ready", i), 72'(bus.c_ready), 72'(tbl[i].ecr));
      chk($sformatf("v%0d d_ready", i), 72'(bus.d_ready), 72'(tbl[i].edr));
      chk($sformatf("v%0d t_valid", i), 72'(bus.t_valid), 72'(tbl[i].etv));
      if (tbl[i].etv)
        chk($sformatf("v%0d t_kp_dat", i), bus.t_kp_dat, tbl[i].ekp);
      @(posedge clk); #1;
    end

`ifdef P_ENCODE_DAT_STATS_EN
    chk("stats ctrl_cnt", 72'(ctrl_cnt), 72'd5);
    chk("stats beat_cnt", 72'(beat_cnt), 72'd11);
`endif

    // Data without control stalls.
    do_reset();
    drive(0, 8'h0, 8'h0, 1, 64'hDEAD_BEEF, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d d_ready", i), 72'(bus.d_ready), 72'h0);
      chk($sformatf("stall%0d t_valid", i), 72'(bus.t_valid), 72'h0);
      @(posedge clk); #1;
    end

    // Maximum repeat count: 256 beats under one control word.
    do_reset();
    drive(1, 8'h5A, 8'hFF, 0, 64'h0, 1);
    @(negedge clk);
    @(posedge clk); #1;
    first_cr = -1;
    words = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      drive(0, 8'h0, 8'h0, 1, 64'(i), 1);
      @(negedge clk);
      if (!bus.d_ready) bad++;
      if (bus.t_valid) begin
        if (bus.t_kp_dat !== {8'h5A, 64'(words)}) bad++;
        words++;
      end
      if (bus.c_ready && first_cr < 0) first_cr = i;
      @(posedge clk); #1;
    end
    drive(0, 8'h0, 8'h0, 0, 64'h0, 1);
    @(negedge clk);
    if (bus.t_valid) begin
      if (bus.t_kp_dat !== {8'h5A, 64'(words)}) bad++;
      words++;
    end
    chk("maxrpt first c_ready", 72'(first_cr), 72'd255);
    chk("maxrpt words", 72'(words), 72'd256);
    chk("maxrpt content", 72'(bad), 72'd0);
    chk("maxrpt empty c_ready", 72'(bus.c_ready), 72'h1);
    chk("maxrpt empty d_ready", 72'(bus.d_ready), 72'h0);
    @(posedge clk); #1;

    // Reset in the middle of a rpt=5 run with one word buffered.
    do_reset();
    drive(1, 8'hC3, 8'd5, 0, 64'h0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 8'h0, 8'h0, 1, 64'hBEEF, 0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 8'h0, 8'h0, 0, 64'h0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst buffered t_valid", 72'(bus.t_valid), 72'h1);
    chk("midrst buffered t_kp_dat", bus.t_kp_dat, {8'hC3, 64'hBEEF});
    chk("midrst c_ready held", 72'(bus.c_ready), 72'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst t_valid", 72'(bus.t_valid), 72'h0);
    chk("midrst c_ready", 72'(bus.c_ready), 72'h1);
    chk("midrst d_ready", 72'(bus.d_ready), 72'h0);
    chk("midrst t_kp_dat", bus.t_kp_dat, 72'h0);
`ifdef P_ENCODE_DAT_STATS_EN
    chk("midrst beat_cnt", 72'(beat_cnt), 72'h0);
    chk("midrst ctrl_cnt", 72'(ctrl_cnt), 72'h0);
`endif
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/p_encode_dat.md
Name: p_encode_dat

Overview:
- Packing stage directly upstream of the piston decode stage.
- Joins a per-beat data stream with a control stream into one output word, t_kp_dat = {k_ctrl, data}, with k_ctrl in the upper SELOU bits.
- Each control word carries a repeat count, so one k_ctrl value covers c_rpt+1 consecutive data beats.
- Output is registered through a 2-entry skid buffer for full-throughput valid/ready flow.

Parameters:
- SLICES, 4, number of data slices per beat
- PERIN, 16, bits per slice
- SELOU, 8, k_ctrl width
- RPTW, 8, repeat-count width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_dat  in  SLICES*PERIN  data beat
- d_valid  in  1  data valid
- d_ready  out  1  data accepted when d_valid&&d_ready
- c_ctrl  in  SELOU  control word
- c_rpt  in  RPTW  extra beats using this control (0 = one beat)
- c_valid  in  1  control valid
- c_ready  out  1  control accepted when c_valid&&c_ready
- t_kp_dat  out  SELOU+SLICES*PERIN  packed word {ctrl,data}
- t_valid  out  1  output valid
- t_ready  in  1  downstream ready

Behaviour:
- State EMPTY: no control loaded; c_ready=1, d_ready=0.
- State LOADED: ctrl_q/rem_q hold current control; d_ready = skid buffer has a free entry.
- Control accept: ctrl_q<=c_ctrl, rem_q<=c_rpt, state<=LOADED.
- Data fire in LOADED:
  - rem_q>0: rem_q decrements.
  - rem_q==0 (last beat): state<=EMPTY, unless a new control is accepted the same cycle.
- c_ready = EMPTY || (LOADED && rem_q==0 && d_valid && d_ready). Consecutive control words therefore need no bubble.
- In that same-cycle case the new control loads and the state stays LOADED.
- The fired beat always uses the old ctrl_q, never the incoming c_ctrl.
- Skid buffer: 2 entries, {ctrl_q,d_dat} written on data fire.
- Latency: data fire at cycle N gives t_valid at N+1 (empty buffer).
- Throughput: 1 word/cycle while t_ready=1.
- t_valid = entry count != 0. t_kp_dat always shows the oldest entry.
- Output pop on t_valid&&t_ready. Simultaneous push and pop leaves the count unchanged.
- d_ready deasserts only when count==2 with no pop. It is combinational on count and state, not on t_ready.
- t_valid, once high, stays high and t_kp_dat stays stable until the pop.
- c_rpt at maximum (2^RPTW-1) gives 2^RPTW beats; no overflow, since rem_q only counts down.
- Reset mid-operation: state<=EMPTY, rem_q<=0, ctrl_q<=0, count<=0. In-flight entries are dropped.
- Reset values: t_valid=0, t_kp_dat=0, d_ready=0, c_ready=0 while reset is high, then 1 on the first cycle after reset.
- Data arriving while EMPTY stalls (d_ready=0); it is never dropped or padded.

Optional Feature:
- Macro: P_ENCODE_DAT_STATS_EN.
- Defined:
  - Adds output beat_cnt (32 bits) and output ctrl_cnt (32 bits).
  - beat_cnt counts output pops; ctrl_cnt counts control accepts.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package p_encode_pkg:
  - Constants DAT_W = SLICES*PERIN and KP_W = SELOU + DAT_W.
  - Enum enc_state_t {EMPTY, LOADED}.
- One sub-module: p_skid2, a parameterised 2-entry valid/ready skid buffer of width KP_W, reusable by neighbouring stages.

Test Plan:
- Basic pack: after reset, c_ctrl=8'hA5, c_rpt=0, then one beat d_dat=64'h0123_4567_89AB_CDEF -> next cycle t_valid=1, t_kp_dat=72'hA5_0123456789ABCDEF; state returns to EMPTY.
- Repeat: c_ctrl=8'h3C, c_rpt=3, 4 back-to-back beats with t_ready=1 -> 4 words all with ctrl 8'h3C; c_ready goes high only on the 4th data fire.
- Back-to-back control: ctrl 8'h11 (rpt 0) then ctrl 8'h22 (rpt 1), data continuous -> output ctrl sequence 11,22,22 with no bubble cycles.
- Backpressure: t_ready=0 for 5 cycles with data streaming -> exactly 2 words buffered; d_ready=0 after the 2nd; t_kp_dat stable; on release, order is preserved and nothing is lost or duplicated.
- Stall without control: d_valid=1 and c_valid=0 after reset -> d_ready stays 0 and t_valid stays 0 for 10 cycles.
- Reset mid-repeat: assert reset during a rpt=5 run with 1 word buffered -> the next cycle has t_valid=0 and c_ready=1 (EMPTY); the stats counters read 0 when STATS_EN is defined.
